pin_entry_ctrl: RTL and testbench
=================================

Name: pin_entry_ctrl

Overview:
- PIN keypad collector and verifier for an ATM session.
- Sits directly upstream of the session inactivity timer. Drives that timer's start and restart inputs, and consumes its timeout output.
- Buffers keypad digits and compares them against the card's stored PIN on Enter.
- Counts failed attempts and locks the card after MAX_ATTEMPTS failures.

Parameters:
- PIN_DIGITS, 4: number of BCD digits in a PIN (range 1..7).
- MAX_ATTEMPTS, 3: wrong-PIN tries allowed before lock (range 1..3).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- card_in  input  1  level; card present in reader.
- stored_pin  input  4*PIN_DIGITS  BCD PIN; first digit in [3:0], next digit in [7:4], and so on.
- key_valid  input  1  one-cycle keypad strobe.
- key_code  input  4  0..9 digit, 4'hA Enter, 4'hB Clear, other codes ignored.
- timeout  input  1  from inactivity timer.
- timer_start  output  1  held high while a PIN is being entered.
- timer_restart  output  1  one-cycle pulse on every accepted key.
- pin_ok  output  1  level; PIN verified, session granted.
- pin_fail  output  1  one-cycle pulse per wrong PIN.
- session_abort  output  1  one-cycle pulse on timeout abort.
- card_locked  output  1  level; attempts exhausted.
- attempts_left  output  2  remaining tries.
- digit_count  output  3  digits currently buffered (drives the display mask).

Behaviour:
- Reset (rst low, async):
  - state IDLE, buffer and digit_count 0, attempts_left = MAX_ATTEMPTS.
  - All other outputs 0.
- States: IDLE, ENTRY, CHECK, GRANTED, LOCKED.
- IDLE:
  - When card_in is 1, go to ENTRY next edge, with buffer cleared and attempts_left = MAX_ATTEMPTS.
- ENTRY:
  - timer_start = 1 (combinational from state).
  - Digit key with digit_count < PIN_DIGITS: shift the digit into slot digit_count, digit_count+1, timer_restart pulse next cycle.
  - Digit key with a full buffer: digit ignored, timer_restart still pulses.
  - Clear key: digit_count = 0, buffer zeroed, timer_restart pulses.
  - Enter key with digit_count == PIN_DIGITS: go to CHECK.
  - Enter key with a short buffer: no effect except timer_restart.
  - Codes 4'hC to 4'hF: ignored, no restart.
- CHECK:
  - Lasts exactly one cycle; timer_start = 0. Full-width compare of buffer vs stored_pin.
  - Match: go to GRANTED, pin_ok = 1.
  - Mismatch: pin_fail pulses for one cycle, attempts_left decrements, buffer and digit_count clear.
    - If the new attempts_left is 0: go to LOCKED, card_locked = 1.
    - Otherwise: back to ENTRY (the timer restarts naturally because start was low for one cycle).
  - Latency: Enter sampled at edge N; pin_ok or pin_fail visible after edge N+1.
- GRANTED:
  - pin_ok held at 1. Keys ignored. Timer not driven.
- LOCKED:
  - card_locked held at 1; attempts_left = 0. Keys ignored.
  - Exit behaviour is set by the Optional Feature.
- Timeout:
  - When timeout = 1 in ENTRY: session_abort pulses, buffer clears, go to IDLE.
  - attempts_left is reloaded on the next card insertion.
- Card removal:
  - When card_in = 0 in ENTRY, CHECK or GRANTED: go to IDLE next edge.
  - pin_ok clears, buffer clears, no pulses.
- Priority within one cycle: card removal > timeout > key.
  - A key arriving in the same cycle as a timeout is discarded.
- Mid-operation reset: returns everything to the reset values immediately, including clearing card_locked.
- Buffer contents never appear on any output.

Optional Feature:
- Macro: LOCK_RELEASE_EN.
- Defined: in LOCKED, card_in = 0 moves to IDLE next edge. card_locked clears and attempts_left reloads to MAX_ATTEMPTS.
- Undefined: LOCKED is exited only by rst; card removal and reinsertion have no effect.

Test Plan:
- Correct PIN: stored_pin=16'h4321, card_in=1; keys 1,2,3,4,A, each spaced by 3 idle cycles -> timer_restart pulses 5 times, digit_count reaches 4, pin_ok=1 two edges after A, attempts_left=3.
- Wrong then right: keys 1,2,3,5,A -> pin_fail one pulse, attempts_left=2, digit_count=0, back in ENTRY; then 1,2,3,4,A -> pin_ok=1.
- Lockout: three wrong PINs -> after the third, card_locked=1 and attempts_left=0; further keys produce no timer_restart and no pin_fail.
  - With LOCK_RELEASE_EN, card_in 1->0 -> card_locked=0 and attempts_left=3.
  - Without LOCK_RELEASE_EN, card_in 1->0 -> card_locked stays 1 until rst.
- Clear, short Enter and overflow: keys 1,2,B -> digit_count=0; keys 1,2,A -> no CHECK, state stays ENTRY; keys 1,2,3,4,9 -> digit_count stays 4, and A then verifies 4321.
- Timeout race: in ENTRY with 2 digits buffered, assert timeout and key_valid (digit 7) in the same cycle -> session_abort pulse, digit not stored, state IDLE, timer_start=0.
- Async reset mid-CHECK: drop rst between clock edges -> all outputs 0 immediately, attempts_left=3, and no pin_ok or pin_fail afterwards.

Source files
------------

// File: rtl/pin_entry_ctrl.sv
// Purpose : ATM PIN keypad collector/verifier; drives the inactivity timer, counts failures, locks the card.
// Latency : Enter sampled at edge N -> CHECK; pin_ok / pin_fail visible after edge N+1.
// Backpress: none; keypad strobes are single-cycle, and keys outside ENTRY are dropped.
//
// Ports:
//   clk, rst (async, active-low)  | card_in, stored_pin, key_valid, key_code, timeout
//   timer_start, timer_restart, pin_ok, pin_fail, session_abort, card_locked,
//   attempts_left, digit_count
// Optional build macro: LOCK_RELEASE_EN (card removal exits LOCKED and reloads attempts).
module pin_entry_ctrl #(
    parameter int PIN_DIGITS   = 4,
    parameter int MAX_ATTEMPTS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    card_in,
    input  logic [4*PIN_DIGITS-1:0] stored_pin,
    input  logic                    key_valid,
    input  logic [3:0]              key_code,
    input  logic                    timeout,
    output logic                    timer_start,
    output logic                    timer_restart,
    output logic                    pin_ok,
    output logic                    pin_fail,
    output logic                    session_abort,
    output logic                    card_locked,
    output logic [1:0]              attempts_left,
    output logic [2:0]              digit_count
);

    localparam logic [2:0] FULL_CNT = 3'(PIN_DIGITS);
    localparam logic [1:0] MAX_ATT  = 2'(MAX_ATTEMPTS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_CHECK,
        S_GRANTED,
        S_LOCKED
    } state_t;

    state_t                  state_q, state_d;
    logic [4*PIN_DIGITS-1:0] buf_q, buf_d, buf_ins;
    logic [2:0]              cnt_q, cnt_d;
    logic [1:0]              att_q, att_d;
    logic                    restart_q, restart_d;
    logic                    fail_q, fail_d;
    logic                    abort_q, abort_d;

    logic is_digit, is_enter, is_clear;

    assign is_digit = (key_code <= 4'd9);
    assign is_enter = (key_code == 4'hA);
    assign is_clear = (key_code == 4'hB);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            buf_q     <= '0;
            cnt_q     <= '0;
            att_q     <= MAX_ATT;
            restart_q <= 1'b0;
            fail_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
            att_q     <= att_d;
            restart_q <= restart_d;
            fail_q    <= fail_d;
            abort_q   <= abort_d;
        end
    end

    always_comb begin
        // Buffer with the incoming digit dropped into slot cnt_q.
        buf_ins = buf_q;
        for (int i = 0; i < PIN_DIGITS; i++) begin
            if (cnt_q == 3'(i)) buf_ins[4*i +: 4] = key_code;
        end

        state_d   = state_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        att_d     = att_q;
        restart_d = 1'b0;
        fail_d    = 1'b0;
        abort_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (card_in) begin
                    state_d = S_ENTRY;
                    buf_d   = '0;
                    cnt_d   = '0;
                    att_d   = MAX_ATT;
                end
            end
            S_ENTRY: begin
                // Card removal beats timeout, timeout beats any key.
                if (!card_in) begin
                    state_d = S_IDLE;
                    buf_d   = '0;
                    cnt_d   = '0;
                end else if (timeout) begin
                    state_d = S_IDLE;
                    buf_d   = '0;
                    cnt_d   = '0;
                    abort_d = 1'b1;
                end else if (key_valid) begin
                    if (is_digit) begin
                        restart_d = 1'b1;
                        if (cnt_q < FULL_CNT) begin
                            buf_d = buf_ins;
                            cnt_d = cnt_q + 3'd1;
                        end
                    end else if (is_clear) begin
                        restart_d = 1'b1;
                        buf_d     = '0;
                        cnt_d     = '0;
                    end else if (is_enter) begin
                        restart_d = 1'b1;
                        if (cnt_q == FULL_CNT) state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (!card_in) begin
                    state_d = S_IDLE;
                    buf_d   = '0;
                    cnt_d   = '0;
                end else if (buf_q == stored_pin) begin
                    state_d = S_GRANTED;
                end else begin
                    fail_d  = 1'b1;
                    att_d   = att_q - 2'd1;
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = (att_q == 2'd1) ? S_LOCKED : S_ENTRY;
                end
            end
            S_GRANTED: begin
                if (!card_in) begin
                    state_d = S_IDLE;
                    buf_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_LOCKED: begin
`ifdef LOCK_RELEASE_EN
                if (!card_in) begin
                    state_d = S_IDLE;
                    att_d   = MAX_ATT;
                end
`else
                // Only rst leaves this state.
                state_d = S_LOCKED;
`endif
            end
            default: begin
                state_d = S_IDLE;
                buf_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    assign timer_start   = (state_q == S_ENTRY);
    assign timer_restart = restart_q;
    assign pin_ok        = (state_q == S_GRANTED);
    assign pin_fail      = fail_q;
    assign session_abort = abort_q;
    assign card_locked   = (state_q == S_LOCKED);
    assign attempts_left = att_q;
    assign digit_count   = cnt_q;

endmodule

// File: tb/tb_pin_entry_ctrl.sv
// Purpose : directed self-checking bench for pin_entry_ctrl (PIN 4321, 3 attempts).
// Latency : outputs sampled on the falling edge, pulse counters sampled 1ns after the rising edge.
// Backpress: n/a; keys are single-cycle strobes driven on the falling edge.
module tb_pin_entry_ctrl;

    logic        clk;
    logic        rst;
    logic        card_in;
    logic [15:0] stored_pin;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        timeout;
    logic        timer_start;
    logic        timer_restart;
    logic        pin_ok;
    logic        pin_fail;
    logic        session_abort;
    logic        card_locked;
    logic [1:0]  attempts_left;
    logic [2:0]  digit_count;

    int n_checks = 0;
    int n_fail   = 0;
    int n_restart_pulses = 0;
    int n_fail_pulses    = 0;
    int n_abort_pulses   = 0;
    int base_restart, base_fail, base_abort;

    pin_entry_ctrl #(.PIN_DIGITS(4), .MAX_ATTEMPTS(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .card_in       (card_in),
        .stored_pin    (stored_pin),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .timeout       (timeout),
        .timer_start   (timer_start),
        .timer_restart (timer_restart),
        .pin_ok        (pin_ok),
        .pin_fail      (pin_fail),
        .session_abort (session_abort),
        .card_locked   (card_locked),
        .attempts_left (attempts_left),
        .digit_count   (digit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, sampled well clear of both clock edges.
    always @(posedge clk) begin
        #1;
        if (timer_restart) n_restart_pulses++;
        if (pin_fail)      n_fail_pulses++;
        if (session_abort) n_abort_pulses++;
    end

    task automatic check(input string tag, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] c);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = c;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    // Four digits (p[3:0] first), 3 idle cycles apart, then Enter.
    // Returns on the falling edge where the DUT sits in CHECK.
    task automatic enter_pin(input logic [15:0] p);
        for (int i = 0; i < 4; i++) begin
            press(p[4*i +: 4]);
            idle(3);
        end
        press(4'hA);
    endtask

    task automatic insert_card();
        @(negedge clk);
        card_in = 1'b1;
        @(negedge clk);
    endtask

    task automatic remove_card();
        @(negedge clk);
        card_in = 1'b0;
        idle(2);
    endtask

    initial begin
        rst        = 1'b0;
        card_in    = 1'b0;
        stored_pin = 16'h4321;
        key_valid  = 1'b0;
        key_code   = 4'h0;
        timeout    = 1'b0;

        // Reset state
        idle(2);
        check("rst_pin_ok",      pin_ok,        0);
        check("rst_card_locked", card_locked,   0);
        check("rst_attempts",    attempts_left, 3);
        check("rst_digits",      digit_count,   0);
        check("rst_timer_start", timer_start,   0);
        check("rst_restart",     timer_restart, 0);
        rst = 1'b1;
        idle(2);
        check("idle_no_card_start", timer_start, 0);

        // Correct PIN
        insert_card();
        check("ok_entry_start", timer_start,   1);
        check("ok_attempts",    attempts_left, 3);
        base_restart = n_restart_pulses;
        base_fail    = n_fail_pulses;
        press(4'd1); idle(3);
        check("ok_one_digit", digit_count, 1);
        press(4'd2); idle(3);
        press(4'd3); idle(3);
        press(4'd4);
        check("ok_four_digits", digit_count, 4);
        idle(3);
        press(4'hA);
        check("ok_check_start_low", timer_start, 0);
        check("ok_check_pin_ok_low", pin_ok, 0);
        idle(1);
        check("ok_pin_ok",       pin_ok,        1);
        check("ok_attempts_end", attempts_left, 3);
        idle(2);
        check("ok_restarts", n_restart_pulses - base_restart, 5);
        check("ok_no_fail",  n_fail_pulses - base_fail, 0);
        check("ok_granted_no_start", timer_start, 0);

        // Wrong then right
        remove_card();
        check("rm_pin_ok_clear", pin_ok, 0);
        insert_card();
        base_fail = n_fail_pulses;
        enter_pin(16'h5321);
        idle(1);
        check("wr_pin_fail",   pin_fail,      1);
        check("wr_attempts",   attempts_left, 2);
        check("wr_digits",     digit_count,   0);
        check("wr_back_entry", timer_start,   1);
        idle(1);
        check("wr_fail_one_cycle", pin_fail, 0);
        check("wr_fail_count", n_fail_pulses - base_fail, 1);
        enter_pin(16'h4321);
        idle(1);
        check("wr_then_ok", pin_ok, 1);

        // Lockout
        remove_card();
        insert_card();
        check("lk_reload", attempts_left, 3);
        enter_pin(16'h1111); idle(2);
        enter_pin(16'h2222); idle(2);
        check("lk_one_left", attempts_left, 1);
        enter_pin(16'h3333); idle(1);
        check("lk_locked",   card_locked,   1);
        check("lk_att_zero", attempts_left, 0);
        check("lk_no_start", timer_start,   0);
        idle(1);
        base_restart = n_restart_pulses;
        base_fail    = n_fail_pulses;
        press(4'd1);
        press(4'hA);
        idle(3);
        check("lk_no_restart", n_restart_pulses - base_restart, 0);
        check("lk_no_fail",    n_fail_pulses - base_fail, 0);
        remove_card();
`ifdef LOCK_RELEASE_EN
        check("lk_release",        card_locked,   0);
        check("lk_release_reload", attempts_left, 3);
`else
        check("lk_stays_locked", card_locked,   1);
        check("lk_stays_zero",   attempts_left, 0);
        insert_card();
        idle(1);
        check("lk_reinsert_locked", card_locked, 1);
        card_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("lk_rst_unlock", card_locked,   0);
        check("lk_rst_reload", attempts_left, 3);
        @(negedge clk);
        rst = 1'b1;
`endif

        // Clear, short Enter and overflow
        insert_card();
        press(4'd1); press(4'd2); press(4'hB);
        check("cl_clear", digit_count, 0);
        press(4'd1); press(4'd2); press(4'hA);
        idle(1);
        check("cl_short_enter_entry", timer_start, 1);
        check("cl_short_enter_count", digit_count, 2);
        check("cl_short_enter_no_ok", pin_ok,      0);
        press(4'hB);
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd9);
        check("cl_overflow_count", digit_count, 4);
        base_restart = n_restart_pulses;
        press(4'hC);
        idle(2);
        check("cl_code_c_no_restart", n_restart_pulses - base_restart, 0);
        press(4'hA);
        idle(1);
        check("cl_overflow_ok", pin_ok, 1);

        // Timeout racing a key
        remove_card();
        insert_card();
        press(4'd1); press(4'd2);
        check("to_two_digits", digit_count, 2);
        base_abort = n_abort_pulses;
        @(negedge clk);
        timeout   = 1'b1;
        key_valid = 1'b1;
        key_code  = 4'd7;
        @(negedge clk);
        timeout   = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        check("to_abort",       session_abort, 1);
        check("to_digits",      digit_count,   0);
        check("to_idle_start",  timer_start,   0);
        check("to_no_restart",  timer_restart, 0);
        idle(1);
        check("to_abort_one_cycle", session_abort, 0);
        check("to_abort_count", n_abort_pulses - base_abort, 1);

        // Async reset while in CHECK (card still in, now back in ENTRY)
        idle(1);
        press(4'd1); press(4'd2); press(4'd3); press(4'd5);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'hA;
        @(posedge clk);
        #2;
        key_valid = 1'b0;
        key_code  = 4'h0;
        check("ar_in_check", timer_start, 0);
        rst = 1'b0;
        #1;
        check("ar_pin_ok",      pin_ok,        0);
        check("ar_pin_fail",    pin_fail,      0);
        check("ar_locked",      card_locked,   0);
        check("ar_attempts",    attempts_left, 3);
        check("ar_digits",      digit_count,   0);
        check("ar_restart",     timer_restart, 0);
        check("ar_abort",       session_abort, 0);
        base_fail = n_fail_pulses;
        @(negedge clk);
        rst = 1'b1;
        idle(4);
        check("ar_no_ok_after",   pin_ok, 0);
        check("ar_no_fail_after", n_fail_pulses - base_fail, 0);
        check("ar_attempts_after", attempts_left, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
